// File: rtl/sensor_pkg.sv
// Shared types and default tuning for the climate sensor front end.
// Level encoding matches the FSM's temp[1:0] input.
`timescale 1ns/1ps
package sensor_pkg;
   typedef enum logic [1:0] {LVL0, LVL1, LVL2, LVL3} temp_lvl_t;

   localparam int         DW_DEF         = 8;
   localparam int         AVG_LOG2_DEF   = 2;
   localparam logic [7:0] T1_DEF         = 8'd64;
   localparam logic [7:0] T2_DEF         = 8'd128;
   localparam logic [7:0] T3_DEF         = 8'd192;
   localparam logic [7:0] HYST_DEF       = 8'd4;
   localparam int         DEB_CYCLES_DEF = 16;
endpackage

// File: rtl/sensor_conditioner_btn_debounce.sv
// Push-button synchroniser and debouncer.
// BT only follows the button after it holds steady for DEB_CYCLES clocks.
`timescale 1ns/1ps
module btn_debounce
   import sensor_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic BT
);
   localparam int CW = $clog2(DEB_CYCLES);

   logic          s1;
   logic          btn_s;
   logic [CW-1:0] cnt;

   // two-flop synchroniser for the asynchronous button
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1    <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         s1    <= btn_raw;
         btn_s <= s1;
      end
   end

   // count consecutive disagreeing clocks; flip BT when the run is long enough
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         BT  <= 1'b0;
      end else if (btn_s != BT) begin
         if (cnt == CW'(DEB_CYCLES - 1)) begin
            BT  <= btn_s;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else begin
         cnt <= '0;
      end
   end
endmodule

// File: rtl/sensor_conditioner.sv
// Temperature averager + hysteretic level classifier and button debouncer.
// Produces the temp[1:0] and BT inputs of the climate-control FSM.
`timescale 1ns/1ps
module sensor_conditioner
   import sensor_pkg::*;
#(
   parameter int              DW         = DW_DEF,
   parameter int              AVG_LOG2   = AVG_LOG2_DEF,
   parameter logic [DW-1:0]   T1         = T1_DEF,
   parameter logic [DW-1:0]   T2         = T2_DEF,
   parameter logic [DW-1:0]   T3         = T3_DEF,
   parameter logic [DW-1:0]   HYST       = HYST_DEF,
   parameter int              DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] sample_in,
   input  logic          sample_valid,
   input  logic          btn_raw,
   output logic [DW-1:0] avg_out,
   output logic          avg_valid,
   output logic [1:0]    temp,
   output logic          BT
);
   localparam int AW = DW + AVG_LOG2;

   logic [AW-1:0]       acc;
   logic [AW-1:0]       sum;
   logic [AVG_LOG2-1:0] cnt;
   temp_lvl_t           lvl;
   logic [DW-1:0]       t_up;
   logic [DW-1:0]       t_dn;
   logic [DW:0]         up_sum;
   logic [DW-1:0]       up_thr;
   logic [DW-1:0]       dn_thr;

   assign sum = acc + {{AVG_LOG2{1'b0}}, sample_in};

   // boxcar accumulator; the window closes on the last sample's own edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc       <= '0;
         cnt       <= '0;
         avg_out   <= '0;
         avg_valid <= 1'b0;
      end else begin
         avg_valid <= 1'b0;
         if (sample_valid) begin
            if (cnt == '1) begin
               avg_out   <= sum[AW-1:AVG_LOG2];
               avg_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + AVG_LOG2'(1);
            end
         end
      end
   end

   // thresholds around the current level, hysteresis saturated to the DW range
   always_comb begin
      t_up = T1;
      t_dn = T1;
      unique case (lvl)
         LVL0: begin t_up = T1; t_dn = T1; end
         LVL1: begin t_up = T2; t_dn = T1; end
         LVL2: begin t_up = T3; t_dn = T2; end
         LVL3: begin t_up = T3; t_dn = T3; end
      endcase
      up_sum = {1'b0, t_up} + {1'b0, HYST};
      up_thr = up_sum[DW] ? '1 : up_sum[DW-1:0];
      dn_thr = (t_dn < HYST) ? '0 : t_dn - HYST;
   end

   // level FSM: at most one step per completed average
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl <= LVL0;
      end else if (avg_valid) begin
         if (lvl != LVL3 && avg_out >= up_thr)
            lvl <= temp_lvl_t'(lvl + 2'd1);
         else if (lvl != LVL0 && avg_out < dn_thr)
            lvl <= temp_lvl_t'(lvl - 2'd1);
      end
   end

   assign temp = lvl;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_raw),
      .BT      (BT)
   );
endmodule
